// File: rtl/rv32i_mem_pkg.sv
// ============================================================================
// rv32i_mem_pkg: shared types/constants for the memory port arbiter. Rev 1.0
// ============================================================================
`default_nettype none

package rv32i_mem_pkg;

  localparam int CTRL_W   = 3;
  localparam int STARVE_W = 4;

  // Fetches always go out as full-word reads.
  localparam logic [CTRL_W-1:0] CTRL_FETCH = 3'b010;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_arb_priority.sv
// ============================================================================
// mem_arb_priority: data-first winner selection with fetch starvation guard. Rev 1.0
// ============================================================================
`default_nettype none

module mem_arb_priority
  import rv32i_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic fetch_ok_i,
  input  logic data_ok_i,
  output logic grant_fetch_o,
  output logic grant_data_o
);

  localparam logic [STARVE_W-1:0] c_limit = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                fetch_prio;

  assign fetch_prio    = fetch_ok_i && (starve_q == c_limit);
  assign grant_data_o  = arb_en_i && data_ok_i && !fetch_prio;
  assign grant_fetch_o = arb_en_i && fetch_ok_i && !grant_data_o;

  // Counts data wins over a raised fetch request; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (grant_fetch_o) begin
      starve_d = '0;
    end else if (grant_data_o && if_req_i && (starve_q != c_limit)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one memory port between fetch and data requesters. Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int size         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [size-1:0]   if_addr_i,
  input  logic              if_flush_i,
  output logic [size-1:0]   if_rdata_o,
  output logic              if_valid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [size-1:0]   d_addr_i,
  input  logic [size-1:0]   d_wdata_i,
  input  logic [CTRL_W-1:0] d_ctrl_i,
  output logic [size-1:0]   d_rdata_o,
  output logic              d_done_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [size-1:0]   mem_addr_o,
  output logic [size-1:0]   mem_wdata_o,
  output logic [CTRL_W-1:0] mem_ctrl_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [size-1:0]   mem_rdata_i
);

  arb_state_e        state_q;
  owner_e            owner_q;
  logic              drop_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [size-1:0]   mem_addr_q;
  logic [size-1:0]   mem_wdata_q;
  logic [CTRL_W-1:0] mem_ctrl_q;
  logic              if_valid_q;
  logic [size-1:0]   if_rdata_q;
  logic              d_done_q;
  logic [size-1:0]   d_rdata_q;

  logic arb_en;
  logic fetch_ok;
  logic grant_fetch;
  logic grant_data;
  logic flush_owned;

  assign arb_en      = (state_q == IDLE);
  assign fetch_ok    = if_req_i && !if_flush_i;
  assign flush_owned = if_flush_i && (owner_q == OWN_FETCH);

  mem_arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_priority (
    .clk           (clk),
    .reset         (reset),
    .arb_en_i      (arb_en),
    .if_req_i      (if_req_i),
    .fetch_ok_i    (fetch_ok),
    .data_ok_i     (d_req_i),
    .grant_fetch_o (grant_fetch),
    .grant_data_o  (grant_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ctrl_q  <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_done_q    <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            owner_q     <= OWN_DATA;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            mem_ctrl_q  <= d_ctrl_i;
            mem_req_q   <= 1'b1;
            drop_q      <= 1'b0;
            state_q     <= ISSUE;
          end else if (grant_fetch) begin
            owner_q     <= OWN_FETCH;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
            mem_ctrl_q  <= CTRL_FETCH;
            mem_req_q   <= 1'b1;
            drop_q      <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush_owned) begin
            drop_q <= 1'b1;
          end
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            // A flush arriving together with the response still discards it.
            if (owner_q == OWN_FETCH) begin
              if (!(drop_q || if_flush_i)) begin
                if_valid_q <= 1'b1;
                if_rdata_q <= mem_rdata_i;
              end
            end else begin
              d_done_q  <= 1'b1;
              d_rdata_q <= mem_we_q ? '0 : mem_rdata_i;
            end
          end else if (flush_owned) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_ctrl_o  = mem_ctrl_q;
  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_done_o    = d_done_q;
  assign d_rdata_o   = d_rdata_q;
  assign stall_o     = d_req_i && !d_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: directed plus randomized bench with a transaction-level model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int W   = 32;
  localparam int LIM = 4;

  logic          clk;
  logic          reset;
  logic          if_req_i;
  logic [W-1:0]  if_addr_i;
  logic          if_flush_i;
  logic [W-1:0]  if_rdata_o;
  logic          if_valid_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [W-1:0]  d_addr_i;
  logic [W-1:0]  d_wdata_i;
  logic [2:0]    d_ctrl_i;
  logic [W-1:0]  d_rdata_o;
  logic          d_done_o;
  logic          stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [W-1:0]  mem_addr_o;
  logic [W-1:0]  mem_wdata_o;
  logic [2:0]    mem_ctrl_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [W-1:0]  mem_rdata_i;

  mem_port_arbiter #(
    .size         (W),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_flush_i   (if_flush_i),
    .if_rdata_o   (if_rdata_o),
    .if_valid_o   (if_valid_o),
    .d_req_i      (d_req_i),
    .d_we_i       (d_we_i),
    .d_addr_i     (d_addr_i),
    .d_wdata_i    (d_wdata_i),
    .d_ctrl_i     (d_ctrl_i),
    .d_rdata_o    (d_rdata_o),
    .d_done_o     (d_done_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ctrl_o   (mem_ctrl_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int completions = 0;

  // Reference model: one bus transaction at a time, tracked as
  // "transaction open" / "address accepted" plus the outputs it implies.
  bit          m_open;
  bit          m_accepted;
  bit          m_is_fetch;
  bit          m_is_store;
  bit          m_discard;
  int          m_data_wins;
  logic        e_mem_req;
  logic        e_mem_we;
  logic [31:0] e_mem_addr;
  logic [31:0] e_mem_wdata;
  logic [2:0]  e_mem_ctrl;
  logic        e_if_valid;
  logic [31:0] e_if_rdata;
  logic        e_d_done;
  logic [31:0] e_d_rdata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_open = 0; m_accepted = 0; m_is_fetch = 0; m_is_store = 0;
    m_discard = 0; m_data_wins = 0;
    e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_ctrl = 0;
    e_if_valid = 0; e_if_rdata = 0; e_d_done = 0; e_d_rdata = 0;
  endfunction

  // Predicts the outputs after the coming rising edge from the present inputs.
  function automatic void model_advance();
    bit fetch_wants;
    bit data_takes;
    if (reset) begin
      model_reset();
      return;
    end
    e_if_valid = 0;
    e_d_done   = 0;
    if (!m_open) begin
      fetch_wants = if_req_i && !if_flush_i;
      data_takes  = d_req_i && !(fetch_wants && m_data_wins == LIM);
      if (data_takes) begin
        if (if_req_i && m_data_wins < LIM) m_data_wins++;
        m_open = 1; m_is_fetch = 0; m_is_store = d_we_i; m_discard = 0;
        e_mem_req = 1; e_mem_we = d_we_i; e_mem_addr = d_addr_i;
        e_mem_wdata = d_wdata_i; e_mem_ctrl = d_ctrl_i;
      end else if (fetch_wants) begin
        m_data_wins = 0;
        m_open = 1; m_is_fetch = 1; m_is_store = 0; m_discard = 0;
        e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr_i;
        e_mem_wdata = 0; e_mem_ctrl = 3'b010;
      end
    end else begin
      if (m_is_fetch && if_flush_i) m_discard = 1;
      if (!m_accepted) begin
        if (mem_gnt_i) begin
          m_accepted = 1;
          e_mem_req  = 0;
        end
      end else if (mem_rvalid_i) begin
        m_open = 0;
        m_accepted = 0;
        completions++;
        if (m_is_fetch) begin
          if (!m_discard) begin
            e_if_valid = 1;
            e_if_rdata = mem_rdata_i;
          end
        end else begin
          e_d_done  = 1;
          e_d_rdata = m_is_store ? 32'h0 : mem_rdata_i;
        end
        m_discard = 0;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("mem_req_o",   mem_req_o,   e_mem_req);
    chk("mem_we_o",    mem_we_o,    e_mem_we);
    chk("mem_addr_o",  mem_addr_o,  e_mem_addr);
    chk("mem_wdata_o", mem_wdata_o, e_mem_wdata);
    chk("mem_ctrl_o",  mem_ctrl_o,  e_mem_ctrl);
    chk("if_valid_o",  if_valid_o,  e_if_valid);
    chk("if_rdata_o",  if_rdata_o,  e_if_rdata);
    chk("d_done_o",    d_done_o,    e_d_done);
    chk("d_rdata_o",   d_rdata_o,   e_d_rdata);
  endtask

  // One clock: stall is checked against the freshly driven inputs, then the
  // model advances and the registered outputs are compared after the edge.
  task automatic step();
    #1;
    chk("stall_o", stall_o, d_req_i & ~e_d_done);
    model_advance();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    reset = 1; if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_ctrl_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    step(); step();
    chk("reset_mem_req", mem_req_o, 0);
    chk("reset_mem_addr", mem_addr_o, 0);
    chk("reset_if_valid", if_valid_o, 0);
    reset = 0;

    // Fetch only, minimum latency
    if_req_i = 1; if_addr_i = 32'h100; mem_gnt_i = 1;
    step();
    chk("fetch_req_N+1", mem_req_o, 1);
    chk("fetch_addr", mem_addr_o, 32'h100);
    step();
    chk("fetch_req_dropped", mem_req_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
    step();
    chk("fetch_valid_N+3", if_valid_o, 1);
    chk("fetch_rdata", if_rdata_o, 32'h0000_0013);
    if_req_i = 0; mem_rvalid_i = 0;
    step();
    chk("fetch_valid_one_cycle", if_valid_o, 0);

    // Simultaneous store and fetch: store first
    if_req_i = 1; if_addr_i = 32'h100;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_wdata_i = 32'hDEAD_BEEF; d_ctrl_i = 3'b010;
    step();
    chk("store_first_we", mem_we_o, 1);
    chk("store_first_addr", mem_addr_o, 32'h2000);
    chk("store_first_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    step();
    mem_rvalid_i = 1; mem_rdata_i = 32'h55AA_55AA;
    step();
    chk("store_done", d_done_o, 1);
    chk("store_rdata_zero", d_rdata_o, 0);
    d_req_i = 0; mem_rvalid_i = 0;
    step();
    chk("then_fetch_req", mem_req_o, 1);
    chk("then_fetch_addr", mem_addr_o, 32'h100);
    chk("then_fetch_we", mem_we_o, 0);
    step();
    mem_rvalid_i = 1;
    step();
    chk("then_fetch_valid", if_valid_o, 1);

    // Starvation: D D D D F D D D D F with both requests held
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h3000; d_ctrl_i = 3'b100;
    for (int t = 0; t < 10; t++) begin
      step();
      chk("starve_grant_addr", mem_addr_o, (t % 5 == 4) ? 32'h100 : 32'h3000);
      step();
      step();
    end
    if_req_i = 0; d_req_i = 0; mem_rvalid_i = 0;
    step();

    // Grant backpressure on a store
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h4000; d_wdata_i = 32'h1234_5678; d_ctrl_i = 3'b001;
    mem_gnt_i = 0;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_req_held", mem_req_o, 1);
      chk("bp_addr_held", mem_addr_o, 32'h4000);
      chk("bp_wdata_held", mem_wdata_o, 32'h1234_5678);
      chk("bp_stall", stall_o, 1);
    end
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1;
    step();
    chk("bp_done", d_done_o, 1);
    chk("bp_stall_released", stall_o, 0);
    d_req_i = 0; mem_rvalid_i = 0;
    step();

    // Flush of a fetch in WAIT_RESP
    if_req_i = 1; if_addr_i = 32'h200; mem_gnt_i = 1;
    step(); step();
    if_flush_i = 1;
    step();
    if_flush_i = 0; if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    step();
    chk("flush_no_valid", if_valid_o, 0);
    chk("flush_rdata_kept", if_rdata_o, 32'h55AA_55AA);
    mem_rvalid_i = 0;
    step();
    chk("flush_idle_no_req", mem_req_o, 0);
    if_req_i = 1; if_addr_i = 32'h204;
    step();
    chk("after_flush_new_req", mem_req_o, 1);
    chk("after_flush_addr", mem_addr_o, 32'h204);

    // Reset while waiting for the response, late rvalid afterwards
    step();
    reset = 1; if_req_i = 0; mem_gnt_i = 0;
    step();
    reset = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
    step();
    chk("late_rvalid_no_valid", if_valid_o, 0);
    chk("late_rvalid_no_done", d_done_o, 0);
    chk("late_rvalid_mem_addr", mem_addr_o, 0);
    mem_rvalid_i = 0;
    step();

    // Randomized traffic
    completions = 0;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 699) == 0);
      if (!d_req_i || d_done_o) begin
        if ($urandom_range(0, 1) == 1) begin
          d_req_i   = 1;
          d_we_i    = 1'($urandom_range(0, 1));
          d_addr_i  = $urandom;
          d_wdata_i = $urandom;
          d_ctrl_i  = 3'($urandom_range(0, 7));
        end else begin
          d_req_i = 0;
        end
      end
      if ($urandom_range(0, 11) == 0) begin
        if_flush_i = 1;
        if_req_i   = 1'($urandom_range(0, 1));
        if_addr_i  = $urandom & 32'hFFFF_FFFC;
      end else begin
        if_flush_i = 0;
        if (!if_req_i || if_valid_o) begin
          if_req_i  = 1'($urandom_range(0, 1));
          if_addr_i = $urandom & 32'hFFFF_FFFC;
        end
      end
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = $urandom;
      step();
    end
    chk("random_progress", (completions > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
